pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Generates per-stage enable/flush/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
//  registers and the PC. All of these are built from enable flip-flops.
//  Detects load-use hazards, freezes the pipe for multi-cycle data-memory accesses, and
//  flushes IF/ID on a taken branch. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_AW    5   register-index width
//  ZERO_REG  31  index of XZR; never a hazard source
//  MEM_LAT   2   freeze cycles per data-memory access; 0 = memory never stalls
//  CNT_W     32  stall-counter width
// PORTS
//  clk          in   1       pipeline clock
//  reset        in   1       asynchronous, active-high
//  id_rn        in   REG_AW  ID-stage first source register
//  id_rm        in   REG_AW  ID-stage second source register
//  id_uses_rn   in   1       ID instruction reads rn
//  id_uses_rm   in   1       ID instruction reads rm
//  ex_mem_read  in   1       EX-stage instruction is a load
//  ex_rd        in   REG_AW  EX-stage destination register
//  mem_req      in   1       MEM-stage instruction accesses data memory (level, held while in MEM)
//  branch_taken in   1       ID-stage branch resolved taken
//  clr_stats    in   1       synchronous clear of stall_cycles
//  pc_en        out  1       PC write enable
//  ifid_en      out  1       IF/ID write enable
//  idex_en      out  1       ID/EX write enable
//  exmem_en     out  1       EX/MEM write enable
//  memwb_en     out  1       MEM/WB write enable
//  ifid_flush   out  1       load NOP into IF/ID at next edge
//  idex_bubble  out  1       load NOP into ID/EX at next edge
//  stall_cycles out  CNT_W   saturating count of cycles with pc_en==0
// BEHAVIOUR
//  Reset (async, any time incl. mid-wait):
//   - state=RUN, wait_cnt=0, branch_pending=0, stall_cycles=0.
//   - While reset is high: all *_en=0, ifid_flush=0, idex_bubble=0.
//  FSM RUN / WAIT / DONE; outputs are combinational from state and inputs (0 latency).
//   - RUN & mem_req & MEM_LAT>0: freeze this cycle; wait_cnt<=MEM_LAT-1;
//     next state = MEM_LAT==1 ? DONE : WAIT.
//   - WAIT: freeze; wait_cnt--; at wait_cnt==1 go to DONE. Total freeze = MEM_LAT cycles.
//   - DONE: no freeze, mem_req ignored (the same instruction leaves MEM); go to RUN.
//  Freeze: all five *_en=0; flush=0; bubble=0.
//  Load-use: lu = ex_mem_read & ex_rd!=ZERO_REG & ((id_uses_rn & id_rn==ex_rd) |
//  (id_uses_rm & id_rm==ex_rd)).
//   - When not frozen and lu: pc_en=ifid_en=0, idex_bubble=1, idex/exmem/memwb_en=1.
//  Priority: freeze > load-use > branch flush.
//  Branch:
//   - Not frozen, no lu, and (branch_taken | branch_pending): ifid_flush=1, all en=1,
//     branch_pending<=0.
//   - branch_taken while frozen: branch_pending<=1; flush issued on first unfrozen cycle.
//   - branch_taken during lu: dropped (the branch stays in ID and re-asserts).
//  Default (none of the above): all en=1, flush=0, bubble=0.
//  stall_cycles: +1 each cycle pc_en==0 outside reset; saturates at all-ones.
//   clr_stats wins over increment.
// STRUCTURE
//  cpu_pipe_pkg: REG_AW, ZERO_REG, typedef enum logic[1:0] {RUN,WAIT,DONE} hz_state_e.
//  Sub-module: sat_counter #(W) (clk, reset, inc, clr, q) for stall_cycles.
//  FSM and wait_cnt (width $clog2(MEM_LAT+1)) stay inline.
// TESTING
//  1. Load-use on rn:
//     ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1
//     -> pc_en=ifid_en=0, idex_bubble=1, exmem_en=1 for 1 cycle; stall_cycles=1.
//  2. Same as 1 but ex_rd=31 (XZR), or id_uses_rn=0
//     -> no stall; all en=1.
//  3. MEM_LAT=2, mem_req held high 3 cycles
//     -> all en=0 for cycles 0-1; cycle 2 all en=1 (DONE); stall_cycles=2.
//  4. branch_taken pulse in freeze cycle 0
//     -> no flush while frozen; ifid_flush=1 in DONE cycle; then branch_pending=0.
//  5. branch_taken and lu in the same cycle
//     -> bubble only, no flush; next cycle branch_taken alone -> ifid_flush=1.
//  6. reset asserted mid-WAIT
//     -> outputs drop immediately; after release state=RUN, stall_cycles=0.
//     Also: CNT_W=4 with 20 stall cycles -> stays 15; clr_stats -> 0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types for the pipeline hazard controller: register-file constants,
// FSM state encoding and the bundle of per-stage control outputs.
package cpu_pipe_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ZERO_REG = 31;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_bubble;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: pipeline status in (master drives), stage controls out (slave drives).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_AW = cpu_pipe_pkg::REG_AW,
    parameter int unsigned CNT_W  = 32
) ();

    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic              id_uses_rn;
    logic              id_uses_rm;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_req;
    logic              branch_taken;
    logic              clr_stats;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_mem_read, ex_rd,
               mem_req, branch_taken, clr_stats,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_bubble, stall_cycles
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_mem_read, ex_rd,
               mem_req, branch_taken, clr_stats,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_bubble, stall_cycles
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-access freeze, load-use bubble and
// taken-branch flush for the five pipeline register enables, plus a stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW   = cpu_pipe_pkg::REG_AW,
    parameter int unsigned ZERO_REG = cpu_pipe_pkg::ZERO_REG,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    import cpu_pipe_pkg::*;

    localparam int unsigned WC_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [REG_AW-1:0] ZR_IDX = REG_AW'(ZERO_REG);

    hz_state_e       r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_branch_pending;

    logic     w_mem_start;
    logic     w_freeze;
    logic     w_rn_hit;
    logic     w_rm_hit;
    logic     w_lu;
    logic     w_take_branch;
    logic     w_stall_inc;
    hz_ctrl_t w_ctrl;

    // Hazard detection; DONE lets the finished access leave MEM without re-freezing.
    always_comb begin
        w_mem_start   = (MEM_LAT != 0) && (r_state == RUN) && bus.mem_req;
        w_freeze      = w_mem_start || (r_state == WAIT);
        w_rn_hit      = bus.id_uses_rn && (bus.id_rn == bus.ex_rd);
        w_rm_hit      = bus.id_uses_rm && (bus.id_rm == bus.ex_rd);
        w_lu          = bus.ex_mem_read && (bus.ex_rd != ZR_IDX) && (w_rn_hit || w_rm_hit);
        w_take_branch = !w_freeze && !w_lu && (bus.branch_taken || r_branch_pending);
    end

    // Control outputs: freeze > load-use > branch flush > free-run.
    always_comb begin
        w_ctrl = '0;
        if (!reset) begin
            if (w_freeze) begin
                w_ctrl = '0;
            end else if (w_lu) begin
                w_ctrl.idex_en     = 1'b1;
                w_ctrl.exmem_en    = 1'b1;
                w_ctrl.memwb_en    = 1'b1;
                w_ctrl.idex_bubble = 1'b1;
            end else begin
                w_ctrl.pc_en      = 1'b1;
                w_ctrl.ifid_en    = 1'b1;
                w_ctrl.idex_en    = 1'b1;
                w_ctrl.exmem_en   = 1'b1;
                w_ctrl.memwb_en   = 1'b1;
                w_ctrl.ifid_flush = w_take_branch;
            end
        end
    end

    assign bus.pc_en       = w_ctrl.pc_en;
    assign bus.ifid_en     = w_ctrl.ifid_en;
    assign bus.idex_en     = w_ctrl.idex_en;
    assign bus.exmem_en    = w_ctrl.exmem_en;
    assign bus.memwb_en    = w_ctrl.memwb_en;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_bubble = w_ctrl.idex_bubble;

    // Memory-wait FSM and deferred-branch flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= RUN;
            r_wait_cnt       <= '0;
            r_branch_pending <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_start) begin
                        r_wait_cnt <= WC_W'(MEM_LAT - 1);
                        r_state    <= (MEM_LAT == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - WC_W'(1);
                    if (r_wait_cnt == WC_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= RUN;
                default: r_state <= RUN;
            endcase

            if (w_freeze && bus.branch_taken) begin
                r_branch_pending <= 1'b1;
            end else if (w_take_branch) begin
                r_branch_pending <= 1'b0;
            end
        end
    end

    assign w_stall_inc = !reset && !w_ctrl.pc_en;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (bus.clr_stats),
        .q     (bus.stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench with an expectation queue checked by an independent monitor.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  sbus ();

    pipeline_hazard_ctrl #(.REG_AW(5), .ZERO_REG(31), .MEM_LAT(2), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .ZERO_REG(31), .MEM_LAT(2), .CNT_W(4)) sdut (
        .clk   (clk),
        .reset (rst),
        .bus   (sbus)
    );

    typedef struct {
        logic       rst;
        logic       mrd;
        logic [4:0] exrd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urn;
        logic       urm;
        logic       mreq;
        logic       bt;
        logic       clr;
        logic       slu;
        logic       sclr;
    } stim_t;

    typedef struct {
        string       nm;
        logic [4:0]  en;
        logic        fl;
        logic        bb;
        logic [31:0] cnt;
        logic [3:0]  scnt;
    } exp_t;

    exp_t exq[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   drv_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t st_idle();
        stim_t s;
        s.rst = 1'b0; s.mrd = 1'b0; s.exrd = 5'd0; s.rn = 5'd0; s.rm = 5'd0;
        s.urn = 1'b0; s.urm = 1'b0; s.mreq = 1'b0; s.bt = 1'b0; s.clr = 1'b0;
        s.slu = 1'b0; s.sclr = 1'b0;
        return s;
    endfunction

    function automatic stim_t st_lu();
        stim_t s;
        s = st_idle();
        s.mrd = 1'b1; s.exrd = 5'd3; s.rn = 5'd3; s.urn = 1'b1;
        return s;
    endfunction

    function automatic stim_t st_mreq();
        stim_t s;
        s = st_idle();
        s.mreq = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst              = s.rst;
        bus.ex_mem_read  = s.mrd;
        bus.ex_rd        = s.exrd;
        bus.id_rn        = s.rn;
        bus.id_rm        = s.rm;
        bus.id_uses_rn   = s.urn;
        bus.id_uses_rm   = s.urm;
        bus.mem_req      = s.mreq;
        bus.branch_taken = s.bt;
        bus.clr_stats    = s.clr;
        sbus.ex_mem_read  = s.slu;
        sbus.ex_rd        = 5'd3;
        sbus.id_rn        = 5'd3;
        sbus.id_rm        = 5'd0;
        sbus.id_uses_rn   = 1'b1;
        sbus.id_uses_rm   = 1'b0;
        sbus.mem_req      = 1'b0;
        sbus.branch_taken = 1'b0;
        sbus.clr_stats    = s.sclr;
    endtask

    task automatic step(input stim_t s, input string nm, input logic [4:0] en,
                        input logic fl, input logic bb, input logic [31:0] cnt,
                        input logic [3:0] scnt);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.nm = nm; e.en = en; e.fl = fl; e.bb = bb; e.cnt = cnt; e.scnt = scnt;
        exq.push_back(e);
    endtask

    // Stimulus: expected values are hand-derived; cnt is the stall count seen in that cycle.
    initial begin : driver
        stim_t s;
        s = st_idle(); s.rst = 1'b1;
        apply(s);
        step(s, "in_reset", 5'b00000, 1'b0, 1'b0, 32'd0, 4'd0);
        step(st_idle(), "idle_after_reset", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd0);

        step(st_lu(), "lu_rn", 5'b00111, 1'b0, 1'b1, 32'd0, 4'd0);
        step(st_idle(), "after_lu_rn", 5'b11111, 1'b0, 1'b0, 32'd1, 4'd0);
        s = st_idle(); s.mrd = 1'b1; s.exrd = 5'd7; s.rm = 5'd7; s.urm = 1'b1; s.rn = 5'd3; s.urn = 1'b1;
        step(s, "lu_rm", 5'b00111, 1'b0, 1'b1, 32'd1, 4'd0);
        step(st_idle(), "after_lu_rm", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);
        s = st_idle(); s.mrd = 1'b1; s.exrd = 5'd31; s.rn = 5'd31; s.urn = 1'b1; s.rm = 5'd31; s.urm = 1'b1;
        step(s, "xzr_no_hazard", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);
        s = st_lu(); s.urn = 1'b0; s.rm = 5'd3; s.urm = 1'b0;
        step(s, "uses_off", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);
        s = st_lu(); s.mrd = 1'b0;
        step(s, "not_a_load", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);

        step(st_mreq(), "mem_freeze0", 5'b00000, 1'b0, 1'b0, 32'd2, 4'd0);
        step(st_mreq(), "mem_freeze1", 5'b00000, 1'b0, 1'b0, 32'd3, 4'd0);
        step(st_mreq(), "mem_done", 5'b11111, 1'b0, 1'b0, 32'd4, 4'd0);
        step(st_idle(), "after_mem", 5'b11111, 1'b0, 1'b0, 32'd4, 4'd0);

        s = st_mreq(); s.bt = 1'b1;
        step(s, "br_in_freeze0", 5'b00000, 1'b0, 1'b0, 32'd4, 4'd0);
        step(st_mreq(), "br_freeze1", 5'b00000, 1'b0, 1'b0, 32'd5, 4'd0);
        step(st_mreq(), "br_pending_flush", 5'b11111, 1'b1, 1'b0, 32'd6, 4'd0);
        step(st_idle(), "br_pending_clear", 5'b11111, 1'b0, 1'b0, 32'd6, 4'd0);

        s = st_lu(); s.bt = 1'b1;
        step(s, "br_with_lu", 5'b00111, 1'b0, 1'b1, 32'd6, 4'd0);
        s = st_idle(); s.bt = 1'b1;
        step(s, "br_reassert", 5'b11111, 1'b1, 1'b0, 32'd7, 4'd0);
        step(st_idle(), "after_br", 5'b11111, 1'b0, 1'b0, 32'd7, 4'd0);

        s = st_lu(); s.mreq = 1'b1;
        step(s, "freeze_over_lu0", 5'b00000, 1'b0, 1'b0, 32'd7, 4'd0);
        step(s, "freeze_over_lu1", 5'b00000, 1'b0, 1'b0, 32'd8, 4'd0);
        step(s, "done_then_lu", 5'b00111, 1'b0, 1'b1, 32'd9, 4'd0);
        step(st_idle(), "after_freeze_lu", 5'b11111, 1'b0, 1'b0, 32'd10, 4'd0);

        step(st_mreq(), "pre_reset_freeze", 5'b00000, 1'b0, 1'b0, 32'd10, 4'd0);
        s = st_mreq(); s.rst = 1'b1;
        step(s, "reset_mid_wait", 5'b00000, 1'b0, 1'b0, 32'd0, 4'd0);
        step(st_idle(), "release_run", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd0);
        step(st_idle(), "release_idle", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd0);
        step(st_mreq(), "post_rst_freeze0", 5'b00000, 1'b0, 1'b0, 32'd0, 4'd0);
        step(st_mreq(), "post_rst_freeze1", 5'b00000, 1'b0, 1'b0, 32'd1, 4'd0);
        step(st_mreq(), "post_rst_done", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);
        step(st_idle(), "post_rst_idle", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);

        s = st_idle(); s.clr = 1'b1;
        step(s, "clr_stats", 5'b11111, 1'b0, 1'b0, 32'd2, 4'd0);
        step(st_idle(), "after_clr", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd0);

        for (int k = 0; k < 20; k++) begin
            s = st_idle(); s.slu = 1'b1;
            step(s, "sat_ramp", 5'b11111, 1'b0, 1'b0, 32'd0, 4'((k < 15) ? k : 15));
        end
        step(st_idle(), "sat_hold", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd15);
        s = st_idle(); s.sclr = 1'b1;
        step(s, "sat_clr", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd15);
        step(st_idle(), "sat_cleared", 5'b11111, 1'b0, 1'b0, 32'd0, 4'd0);

        drv_done = 1'b1;
    end

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin : monitor
        exp_t       e;
        logic [4:0] got_en;
        int         idle_cyc;
        idle_cyc = 0;
        forever begin
            @(negedge clk);
            if (exq.size() != 0) begin
                idle_cyc = 0;
                e = exq.pop_front();
                got_en = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
                n_vec++;
                if (got_en !== e.en || bus.ifid_flush !== e.fl || bus.idex_bubble !== e.bb ||
                    bus.stall_cycles !== e.cnt || sbus.stall_cycles !== e.scnt) begin
                    n_err++;
                    $display("FAIL %s: got en=%05b flush=%0b bubble=%0b cnt=%0d scnt=%0d, expected en=%05b flush=%0b bubble=%0b cnt=%0d scnt=%0d",
                             e.nm, got_en, bus.ifid_flush, bus.idex_bubble, bus.stall_cycles,
                             sbus.stall_cycles, e.en, e.fl, e.bb, e.cnt, e.scnt);
                end
            end else if (drv_done) begin
                break;
            end else begin
                idle_cyc++;
                if (idle_cyc > 20) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL watchdog: got no stimulus for %0d cycles, expected one per cycle", idle_cyc);
                    break;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
